// File: rtl/cp0_unit.sv
// Coprocessor-0 for the 5-stage MIPS core: Status/Cause/EPC/Count/Compare,
// mfc0/mtc0 bus service, and precise exception/interrupt flush generation.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_ready,
  input  logic [31:0] inst_pc,
  input  logic [37:0] cp0_rw_bus,
  input  logic        s_syscall,
  input  logic        s_eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_reg_out,
  output logic        exc_flush,
  output logic [31:0] exc_target,
  output logic        timer_irq
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;

  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] epc;
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc_code;

  logic [4:0]  rw_addr;
  logic [31:0] wr_data;
  logic        wr_req;
  logic        accept;
  logic        int_req;
  logic        take_int;
  logic        take_sys;
  logic        take_eret;
  logic        event_taken;
  logic        wr_commit;

  assign wr_data = cp0_rw_bus[31:0];
  assign rw_addr = cp0_rw_bus[36:32];
  assign wr_req  = cp0_rw_bus[37];

  // Nothing in ID is accepted while its instruction is being squashed.
  assign accept      = pipe_ready & ~exc_flush;
  assign int_req     = status_ie & ~status_exl &
                       (|({cause_ip_hw, cause_ip_sw} & status_im));
  assign take_int    = accept & int_req;
  assign take_sys    = accept & ~int_req & s_syscall;
  assign take_eret   = accept & ~int_req & ~s_syscall & s_eret;
  assign event_taken = take_int | take_sys | take_eret;
  assign wr_commit   = accept & ~event_taken & wr_req;

  always_comb begin
    cp0_reg_out = 32'd0;
    case (rw_addr)
      REG_COUNT:   cp0_reg_out = count;
      REG_COMPARE: cp0_reg_out = compare;
      REG_STATUS:  cp0_reg_out = {16'd0, status_im, 6'd0, status_exl, status_ie};
      REG_CAUSE:   cp0_reg_out = {16'd0, cause_ip_hw, cause_ip_sw, 1'b0,
                                  cause_exc_code, 2'b00};
      REG_EPC:     cp0_reg_out = epc;
      default:     cp0_reg_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count          <= 32'd0;
      compare        <= 32'hFFFF_FFFF;
      epc            <= 32'd0;
      status_im      <= 8'd0;
      status_exl     <= 1'b0;
      status_ie      <= 1'b0;
      cause_ip_hw    <= 6'd0;
      cause_ip_sw    <= 2'd0;
      cause_exc_code <= 5'd0;
      timer_irq      <= 1'b0;
      exc_flush      <= 1'b0;
      exc_target     <= 32'd0;
    end else begin
      if (wr_commit && rw_addr == REG_COUNT)
        count <= wr_data;
      else
        count <= count + 32'd1;

      // A Compare write acknowledges the timer even if it matches this cycle.
      if (wr_commit && rw_addr == REG_COMPARE) begin
        compare   <= wr_data;
        timer_irq <= 1'b0;
      end else if (count == compare) begin
        timer_irq <= 1'b1;
      end

      cause_ip_hw <= {timer_irq | hw_int[5], hw_int[4:0]};
      exc_flush   <= event_taken;

      // An accepted event suppresses any mtc0 carried by the same instruction.
      if (take_int) begin
        status_exl     <= 1'b1;
        cause_exc_code <= 5'd0;
        epc            <= inst_pc;
        exc_target     <= EXC_VECTOR;
      end else if (take_sys) begin
        status_exl     <= 1'b1;
        cause_exc_code <= EXC_SYSCALL;
        if (!status_exl)
          epc <= inst_pc;
        exc_target     <= EXC_VECTOR;
      end else if (take_eret) begin
        status_exl <= 1'b0;
        exc_target <= epc;
      end else if (wr_commit) begin
        case (rw_addr)
          REG_STATUS: begin
            status_im  <= wr_data[15:8];
            status_exl <= wr_data[1];
            status_ie  <= wr_data[0];
          end
          REG_CAUSE: cause_ip_sw <= wr_data[9:8];
          REG_EPC:   epc <= wr_data;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit: register access, syscall/eret,
// timer interrupt, event priority, pipeline stall and reset during a flush.
module tb_cp0_unit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk;
  logic        rst_n;
  logic        pipe_ready;
  logic [31:0] inst_pc;
  logic [37:0] cp0_rw_bus;
  logic        s_syscall;
  logic        s_eret;
  logic [5:0]  hw_int;
  logic [31:0] cp0_reg_out;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_ready (pipe_ready),
    .inst_pc    (inst_pc),
    .cp0_rw_bus (cp0_rw_bus),
    .s_syscall  (s_syscall),
    .s_eret     (s_eret),
    .hw_int     (hw_int),
    .cp0_reg_out(cp0_reg_out),
    .exc_flush  (exc_flush),
    .exc_target (exc_target),
    .timer_irq  (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic pr, input logic [31:0] pc,
                               input logic we, input logic [4:0] addr,
                               input logic [31:0] data,
                               input logic sys, input logic er);
    pipe_ready = pr;
    inst_pc    = pc;
    cp0_rw_bus = {we, addr, data};
    s_syscall  = sys;
    s_eret     = er;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic readReg(input logic [4:0] addr, output logic [31:0] data);
    cp0_rw_bus = {1'b0, addr, 32'd0};
    #1;
    data = cp0_reg_out;
  endtask

  task automatic checkReg(input string tag, input logic [4:0] addr,
                          input logic [31:0] expected);
    logic [31:0] v;
    readReg(addr, v);
    checkOutput(tag, v, expected);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic doMtc0(input logic [4:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 32'h0040_0000, 1'b1, addr, data, 1'b0, 1'b0);
    tick();
    idle();
  endtask

  initial begin
    logic [31:0] cnt;
    rst_n  = 1'b0;
    hw_int = 6'd0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state and free-running Count.
    checkReg("count_reset", 5'd9, 32'd0);
    checkOutput("flush_reset", {31'd0, exc_flush}, 32'd0);
    checkOutput("target_reset", exc_target, 32'd0);
    checkOutput("timer_reset", {31'd0, timer_irq}, 32'd0);
    tick();
    checkReg("count_plus1", 5'd9, 32'd1);
    tick();
    checkReg("count_plus2", 5'd9, 32'd2);
    checkReg("status_reset", 5'd12, 32'd0);
    checkReg("cause_reset", 5'd13, 32'd0);
    checkReg("epc_reset", 5'd14, 32'd0);
    checkReg("compare_reset", 5'd11, 32'hFFFF_FFFF);
    checkReg("unmapped_reg", 5'd3, 32'd0);

    // Writable-bit masks.
    doMtc0(5'd12, 32'hFFFF_FFFF);
    checkReg("status_mask", 5'd12, 32'h0000_FF03);
    doMtc0(5'd13, 32'hFFFF_FFFF);
    checkReg("cause_mask", 5'd13, 32'h0000_0300);
    doMtc0(5'd13, 32'd0);
    doMtc0(5'd12, 32'd0);
    checkReg("status_cleared", 5'd12, 32'd0);

    // Syscall, nested syscall keeps EPC, eret returns.
    applyStimulus(1'b1, 32'h0040_0010, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("sys1_flush", {31'd0, exc_flush}, 32'd1);
    checkOutput("sys1_target", exc_target, VEC);
    checkReg("sys1_epc", 5'd14, 32'h0040_0010);
    checkReg("sys1_cause", 5'd13, 32'h0000_0020);
    checkReg("sys1_status", 5'd12, 32'h0000_0002);
    tick();
    checkOutput("sys1_flush_end", {31'd0, exc_flush}, 32'd0);
    applyStimulus(1'b1, 32'h0040_0020, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("sys2_flush", {31'd0, exc_flush}, 32'd1);
    checkReg("sys2_epc_kept", 5'd14, 32'h0040_0010);
    tick();
    applyStimulus(1'b1, 32'h0040_0030, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("eret_flush", {31'd0, exc_flush}, 32'd1);
    checkOutput("eret_target", exc_target, 32'h0040_0010);
    checkReg("eret_status", 5'd12, 32'd0);
    tick();

    // Timer interrupt: Compare = Count + 5, IE=1, IM7=1.
    doMtc0(5'd12, 32'h0000_8001);
    readReg(5'd9, cnt);
    applyStimulus(1'b1, 32'h0040_0100, 1'b1, 5'd11, cnt + 32'd5, 1'b0, 1'b0);
    tick();
    cp0_rw_bus = 38'd0;
    repeat (4) tick();
    checkOutput("timer_before_match", {31'd0, timer_irq}, 32'd0);
    tick();
    checkOutput("timer_set", {31'd0, timer_irq}, 32'd1);
    checkOutput("timer_no_flush_yet", {31'd0, exc_flush}, 32'd0);
    tick();
    checkOutput("timer_ip_latency", {31'd0, exc_flush}, 32'd0);
    tick();
    checkOutput("timer_flush", {31'd0, exc_flush}, 32'd1);
    checkOutput("timer_target", exc_target, VEC);
    idle();
    checkReg("timer_epc", 5'd14, 32'h0040_0100);
    checkReg("timer_cause", 5'd13, 32'h0000_8000);
    checkReg("timer_status", 5'd12, 32'h0000_8003);
    tick();
    checkOutput("timer_flush_end", {31'd0, exc_flush}, 32'd0);
    doMtc0(5'd11, 32'hFFFF_FFFF);
    checkOutput("timer_cleared", {31'd0, timer_irq}, 32'd0);
    tick();
    checkReg("ip7_cleared", 5'd13, 32'd0);

    // Interrupt beats a same-cycle syscall; the mtc0 EPC is dropped.
    hw_int = 6'b000001;
    doMtc0(5'd12, 32'h0000_0401);
    applyStimulus(1'b1, 32'h0040_0200, 1'b1, 5'd14, 32'h0000_1234, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("prio_flush", {31'd0, exc_flush}, 32'd1);
    checkOutput("prio_target", exc_target, VEC);
    checkReg("prio_epc", 5'd14, 32'h0040_0200);
    checkReg("prio_cause", 5'd13, 32'h0000_0400);
    checkReg("prio_status", 5'd12, 32'h0000_0403);
    tick();
    checkOutput("prio_flush_end", {31'd0, exc_flush}, 32'd0);

    // Stalled pipeline holds the interrupt pending.
    doMtc0(5'd12, 32'h0000_0401);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("stall_no_flush_%0d", i), {31'd0, exc_flush}, 32'd0);
    end
    pipe_ready = 1'b1;
    inst_pc    = 32'h0040_0300;
    tick();
    checkOutput("stall_release_flush", {31'd0, exc_flush}, 32'd1);
    checkOutput("stall_release_target", exc_target, VEC);

    // Reset during the flush pulse.
    rst_n = 1'b0;
    pipe_ready = 1'b0;
    tick();
    checkOutput("reset_mid_flush", {31'd0, exc_flush}, 32'd0);
    checkOutput("reset_mid_target", exc_target, 32'd0);
    checkReg("reset_mid_status", 5'd12, 32'd0);
    checkReg("reset_mid_epc", 5'd14, 32'd0);
    rst_n  = 1'b1;
    hw_int = 6'd0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 responder for the 5-stage MIPS core: it services the CP0 read/write bus driven by the ID stage (mfc0/mtc0), acts on the stage's syscall/eret decode flags, and owns the Status/Cause/EPC/Count/Compare state. It raises precise exceptions and interrupts by issuing a one-cycle pipeline flush with a redirect target. It sits beside ID and feeds ID's CP0 read-data input and the fetch-stage redirect path.

## Interface
- EXC_VECTOR, 32'hBFC0_0380, handler entry address for interrupts and syscall.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- pipe_ready  in  1  ID instruction advances this cycle; qualifies every event and mtc0.
- inst_pc  in  32  PC of the instruction currently in ID.
- cp0_rw_bus  in  38  [31:0] write data, [36:32] CP0 register number (read and write), [37] write enable (mtc0).
- s_syscall  in  1  ID holds a syscall.
- s_eret  in  1  ID holds an eret.
- hw_int  in  6  level-sensitive external interrupt lines.
- cp0_reg_out  out  32  combinational read data for register cp0_rw_bus[36:32].
- exc_flush  out  1  registered one-cycle flush/redirect pulse.
- exc_target  out  32  redirect PC, valid while exc_flush=1.
- timer_irq  out  1  registered Count==Compare pending flag (Cause.IP7 source).

## Operation
- Registers: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; any other number reads 0, writes ignored.
- Status writable bits [15:8] IM, [1] EXL, [0] IE; all other bits read 0.
- Cause: [15:10] IP7..IP2 read-only hardware pending, [9:8] IP1..IP0 software-writable, [6:2] ExcCode; other bits 0.
- Hardware pending, registered each cycle: IP7 = timer_irq | hw_int[5]; IP6..IP2 = hw_int[4:0].
- Count increments by 1 every cycle and wraps 0xFFFF_FFFF→0; an mtc0 to Count loads the data with no increment that cycle.
- Timer: when Count==Compare, timer_irq is set next cycle and stays set; an mtc0 to Compare clears it (clear wins over a same-cycle match).
- int_req = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM).
- Event arbitration applies only when pipe_ready=1 and exc_flush=0, priority interrupt > syscall > eret.
  - Interrupt: EXL←1, ExcCode←0, EPC←inst_pc, target EXC_VECTOR.
  - Syscall: EXL←1, ExcCode←8, EPC←inst_pc unless EXL already 1 (EPC retained), target EXC_VECTOR.
  - Eret: EXL←0, target = current EPC (also when EXL=0).
- mtc0 commits only when pipe_ready=1, exc_flush=0 and no event is taken that cycle; otherwise it is dropped.
- In the cycle exc_flush=1 the ID instruction is being squashed: no event or mtc0 is accepted.
- Reads are combinational from current state; Count returns the pre-increment value.

## Timing
- Reset (edge with rst_n=0): Count=0, Compare=0xFFFF_FFFF, Status=0, Cause=0, EPC=0, timer_irq=0, exc_flush=0, exc_target=0. Reset mid-flush drops the pulse.
- Event accepted in cycle N: state updates and exc_flush=1/exc_target at edge N+1; exc_flush returns to 0 at edge N+2.
- mtc0 in cycle N is visible to cp0_reg_out in cycle N+1.
- hw_int change in cycle N appears in Cause.IP at N+1; int_req can cause exc_flush at N+2 at the earliest.
- With pipe_ready=0 the interrupt stays pending; it is taken on the first cycle with pipe_ready=1.

## Test plan
- Reset, then read 12, 13, 14, 11 → 0, 0, 0, 0xFFFF_FFFF; Count reads 0 then increments by 1 per cycle.
- mtc0 Status=0xFFFF_FFFF → Status reads 0x0000_FF03; mtc0 Cause=0xFFFF_FFFF → Cause reads 0x0000_0300.
- syscall at inst_pc=0x0040_0010 → one exc_flush, target 0xBFC0_0380, EPC=0x0040_0010, Cause[6:2]=8, EXL=1; second syscall at 0x0040_0020 leaves EPC 0x0040_0010; eret → target 0x0040_0010, EXL=0.
- Status=0x0000_8001, Compare=Count+5 → timer_irq set, flush at PC in ID with ExcCode 0; mtc0 Compare clears timer_irq and IP7.
- hw_int[0]=1 with IE=1, IM2=1, plus same-cycle syscall and mtc0 EPC=0x1234 → interrupt wins (ExcCode 0, EPC=inst_pc); the mtc0 is dropped.
- pipe_ready=0 for 4 cycles with interrupt pending → no flush; flush the cycle after pipe_ready rises; rst_n low during exc_flush → exc_flush=0 next cycle.
